// File: rtl/prio_dec_pkg.sv
// Shared types and constants for the priority grant decoder.
// No logic; the FSM state encoding and counter widths live here.
// Imported by prio_grant_decoder and onehot_dec.
package prio_dec_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } prio_state_e;

    localparam int GNT_CNT_W        = 8;
    localparam int WD_W             = 8;
    localparam int HOLD_MAX_DEFAULT = 16;

endpackage

// File: rtl/onehot_dec.sv
// Index to one-hot decoder; an index >= N yields an all-zero vector.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no handshake.
// Ports: idx - binary index in; oh - one-hot out (zero when idx out of range).
module onehot_dec
    import prio_dec_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [IDX_W-1:0] idx,
    output logic [N-1:0]     oh
);

    // Only bits 0..N-1 exist, so any index >= N matches nothing.
    always_comb begin
        oh = '0;
        for (int i = 0; i < N; i++) begin
            oh[i] = (idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/prio_grant_decoder.sv
// Turns a priority-encoder result into a held one-hot grant; rejects no-match/out-of-range with an err pulse.
// Latency: grant visible one cycle after the accepting edge; one dead RELEASE cycle after done.
// Backpressure: in_ready is high only in IDLE; requests presented in GRANT/RELEASE are left unconsumed.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_idx/in_none request side;
//        done release from the agent; gnt/gnt_valid/busy/err/gnt_cnt registered status outputs.
// Optional: define PRIO_DEC_TIMEOUT_EN to add a watchdog that forces RELEASE after HOLD_MAX GRANT cycles.
module prio_grant_decoder
    import prio_dec_pkg::*;
#(
    parameter int N        = 8,
    parameter int IDX_W    = $clog2(N),
    parameter int HOLD_MAX = HOLD_MAX_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IDX_W-1:0]     in_idx,
    input  logic                 in_none,
    input  logic                 done,
    output logic [N-1:0]         gnt,
    output logic                 gnt_valid,
    output logic                 busy,
    output logic                 err,
    output logic [GNT_CNT_W-1:0] gnt_cnt
);

    if (N < 2 || N > 32) begin : g_bad_n
        $error("prio_grant_decoder: N must be in 2..32");
    end
    if (HOLD_MAX < 1 || HOLD_MAX > 256) begin : g_bad_hold
        $error("prio_grant_decoder: HOLD_MAX must be in 1..256");
    end

    prio_state_e state;
    prio_state_e state_nx;

    logic [N-1:0] dec_oh;
    logic         idx_ok;
    logic         accept;
    logic         reject;
    logic         timeout;
    logic         wd_expired;

    onehot_dec #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_dec (
        .idx (in_idx),
        .oh  (dec_oh)
    );

    // The decoder returns zero for an out-of-range index, so a non-zero
    // result doubles as the range check.
    assign idx_ok   = |dec_oh;
    assign in_ready = (state == IDLE);

`ifdef PRIO_DEC_TIMEOUT_EN
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(HOLD_MAX - 1);

    logic [WD_W-1:0] wd;

    // wd holds the number of GRANT cycles already completed, so it equals
    // WD_LIMIT during the HOLD_MAX-th GRANT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd <= '0;
        end else if (accept) begin
            wd <= '0;
        end else if (state == GRANT) begin
            wd <= wd + WD_W'(1);
        end
    end

    assign wd_expired = (wd == WD_LIMIT);
`else
    assign wd_expired = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        reject   = 1'b0;
        timeout  = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    // in_none overrides whatever is on in_idx.
                    if (in_none || !idx_ok) begin
                        reject = 1'b1;
                    end else begin
                        accept   = 1'b1;
                        state_nx = GRANT;
                    end
                end
            end
            GRANT: begin
                // done on the limit cycle is an ordinary release.
                if (done) begin
                    state_nx = RELEASE;
                end else if (wd_expired) begin
                    state_nx = RELEASE;
                    timeout  = 1'b1;
                end
            end
            RELEASE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            gnt_cnt   <= '0;
        end else begin
            state     <= state_nx;
            err       <= reject | timeout;
            busy      <= (state_nx != IDLE);
            gnt_valid <= (state_nx == GRANT);
            if (accept) begin
                gnt     <= dec_oh;
                gnt_cnt <= gnt_cnt + GNT_CNT_W'(1);
            end else if (state_nx != GRANT) begin
                gnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_prio_grant_decoder.sv
// Self-checking bench for prio_grant_decoder (N=12, HOLD_MAX=6).
// Expected outputs are queued when stimulus is driven and compared one edge later.
// Covers reset, grant/hold/release, rejects, reset corner cases, watchdog (when enabled) and counter wrap.
module tb_prio_grant_decoder;

    localparam int N     = 12;
    localparam int IDX_W = 4;
    localparam int HOLD  = 6;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] in_idx;
    logic             in_none;
    logic             done;
    logic [N-1:0]     gnt;
    logic             gnt_valid;
    logic             busy;
    logic             err;
    logic [7:0]       gnt_cnt;

    prio_grant_decoder #(
        .N        (N),
        .IDX_W    (IDX_W),
        .HOLD_MAX (HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_idx    (in_idx),
        .in_none   (in_none),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .busy      (busy),
        .err       (err),
        .gnt_cnt   (gnt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] gnt;
        logic         gv;
        logic         busy;
        logic         err;
        logic         rdy;
        logic [7:0]   cnt;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic nn,
                         input logic [IDX_W-1:0] ix, input logic d);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        in_none  = nn;
        in_idx   = ix;
        done     = d;
    endtask

    task automatic expect_out(input string tag, input logic [N-1:0] g, input logic gv,
                              input logic b, input logic e, input logic rdy, input logic [7:0] c);
        exp_t x;
        x.gnt  = g;
        x.gv   = gv;
        x.busy = b;
        x.err  = e;
        x.rdy  = rdy;
        x.cnt  = c;
        sb_q.push_back(x);
        tag_q.push_back(tag);
    endtask

    task automatic expect_idle(input string tag, input logic [7:0] c);
        expect_out(tag, '0, 1'b0, 1'b0, 1'b0, 1'b1, c);
    endtask

    task automatic expect_gnt(input string tag, input logic [N-1:0] g, input logic [7:0] c);
        expect_out(tag, g, 1'b1, 1'b1, 1'b0, 1'b0, c);
    endtask

    task automatic expect_rel(input string tag, input logic e, input logic [7:0] c);
        expect_out(tag, '0, 1'b0, 1'b1, e, 1'b0, c);
    endtask

    task automatic expect_err(input string tag, input logic [7:0] c);
        expect_out(tag, '0, 1'b0, 1'b0, 1'b1, 1'b1, c);
    endtask

    // Scoreboard: every queued expectation belongs to the next active edge.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() != 0) begin
            exp_t  e;
            string t;
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            check({t, ".gnt"},       32'(gnt),       32'(e.gnt));
            check({t, ".gnt_valid"}, 32'(gnt_valid), 32'(e.gv));
            check({t, ".busy"},      32'(busy),      32'(e.busy));
            check({t, ".err"},       32'(err),       32'(e.err));
            check({t, ".in_ready"},  32'(in_ready),  32'(e.rdy));
            check({t, ".gnt_cnt"},   32'(gnt_cnt),   32'(e.cnt));
        end
    end

    // Grant shape invariants, sampled mid-cycle.
    always @(negedge clk) begin
        check("onehot0", 32'($onehot0(gnt)), 32'd1);
        if (gnt_valid) begin
            check("onehot", 32'($onehot(gnt)), 32'd1);
        end
    end

    initial begin
        logic [N-1:0] g;
        logic [7:0]   c;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_none  = 1'b0;
        in_idx   = '0;
        done     = 1'b0;

        // Reset state.
        drive(1, 0, 0, 0, 0);  expect_idle("reset", 8'd0);

        // Grant idx 3, hold 5 cycles with in_valid asserted (must be ignored),
        // then done on the 6th GRANT cycle (the watchdog limit cycle when enabled).
        drive(0, 1, 0, 3, 0);  expect_gnt("grant3", 12'h008, 8'd1);
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, 5, 0);  expect_gnt("hold3", 12'h008, 8'd1);
        end
        drive(0, 0, 0, 0, 1);  expect_rel("rel3", 1'b0, 8'd1);
        drive(0, 1, 0, 7, 1);  expect_idle("back_idle", 8'd1);

        // in_none wins over a legal index.
        drive(0, 1, 1, 2, 0);  expect_err("none", 8'd1);
        drive(0, 0, 0, 0, 0);  expect_idle("none_pulse", 8'd1);

        // Out of range: idx == N and idx = 15, back to back.
        drive(0, 1, 0, 12, 0); expect_err("idx12", 8'd1);
        drive(0, 1, 0, 15, 0); expect_err("idx15", 8'd1);
        drive(0, 0, 0, 0, 0);  expect_idle("oor_pulse", 8'd1);

        // Highest legal index, done in the first GRANT cycle.
        drive(0, 1, 0, 11, 0); expect_gnt("grant11", 12'h800, 8'd2);
        drive(0, 0, 0, 0, 1);  expect_rel("rel11", 1'b0, 8'd2);
        drive(0, 0, 0, 0, 0);  expect_idle("idle11", 8'd2);

        // Reset mid-GRANT with in_valid and done also high: reset wins, no RELEASE.
        drive(0, 1, 0, 5, 0);  expect_gnt("grant5", 12'h020, 8'd3);
        drive(0, 0, 0, 0, 0);  expect_gnt("hold5", 12'h020, 8'd3);
        drive(1, 1, 0, 4, 1);  expect_idle("rst_grant", 8'd0);
        drive(0, 0, 0, 0, 1);  expect_idle("done_idle", 8'd0);

        // Reset alongside a request in IDLE: request not consumed.
        drive(1, 1, 0, 2, 0);  expect_idle("rst_req", 8'd0);
        drive(0, 0, 0, 0, 0);  expect_idle("rst_req_after", 8'd0);

        // Long hold with no done.
        drive(0, 1, 0, 0, 0);  expect_gnt("grant0", 12'h001, 8'd1);
        for (int i = 0; i < HOLD - 1; i++) begin
            drive(0, 0, 0, 0, 0);  expect_gnt("hold0", 12'h001, 8'd1);
        end
`ifdef PRIO_DEC_TIMEOUT_EN
        drive(0, 0, 0, 0, 0);  expect_rel("timeout", 1'b1, 8'd1);
        drive(0, 0, 0, 0, 0);  expect_idle("after_timeout", 8'd1);
`else
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 0, 0);  expect_gnt("hold0_long", 12'h001, 8'd1);
        end
        drive(0, 0, 0, 0, 1);  expect_rel("rel0", 1'b0, 8'd1);
        drive(0, 0, 0, 0, 0);  expect_idle("idle0", 8'd1);
`endif

        // 256 grants: gnt_cnt passes 255 -> 0 and ends back at 1.
        for (int k = 0; k < 256; k++) begin
            g = '0;
            g[k % N] = 1'b1;
            c = 8'((2 + k) % 256);
            drive(0, 1, 0, IDX_W'(k % N), 0);  expect_gnt("wrap_gnt", g, c);
            drive(0, 0, 0, 0, 1);              expect_rel("wrap_rel", 1'b0, c);
            drive(0, 0, 0, 0, 0);              expect_idle("wrap_idle", c);
        end

        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        check("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
